// File: rtl/instruction_loader_if.sv
// ----------------------------------------------------------------------------
// instruction_loader_if
//   Groups the debug-unit side (start command and UART byte stream) and the
//   instruction-memory side (packed word, address, write strobe) of the
//   instruction loader together with its status outputs.
//
//   Signals
//     i_start             debug-unit command to begin a load (level)
//     i_rx_valid          one-cycle strobe, i_rx_data holds a new byte
//     i_rx_data           received UART byte
//     o_instruction       packed big-endian instruction word
//     o_address           word address of o_instruction
//     o_instruction_write one-cycle instruction-memory write strobe
//     o_busy              loader is in LOAD
//     o_done              loader is in DONE
//     o_overflow          last load filled the memory without a HALT
//     o_word_count        words written since the last start
//
//   Modports
//     master  debug unit / environment side (drives the i_* signals)
//     slave   the loader itself (drives the o_* signals)
// ----------------------------------------------------------------------------
interface instruction_loader_if #(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8
);

  logic               i_start;
  logic               i_rx_valid;
  logic [NB_BYTE-1:0] i_rx_data;
  logic [NB-1:0]      o_instruction;
  logic [NB-1:0]      o_address;
  logic               o_instruction_write;
  logic               o_busy;
  logic               o_done;
  logic               o_overflow;
  logic [NB-1:0]      o_word_count;

  modport master (
    output i_start,
    output i_rx_valid,
    output i_rx_data,
    input  o_instruction,
    input  o_address,
    input  o_instruction_write,
    input  o_busy,
    input  o_done,
    input  o_overflow,
    input  o_word_count
  );

  modport slave (
    input  i_start,
    input  i_rx_valid,
    input  i_rx_data,
    output o_instruction,
    output o_address,
    output o_instruction_write,
    output o_busy,
    output o_done,
    output o_overflow,
    output o_word_count
  );

endinterface : instruction_loader_if

// File: rtl/instruction_loader.sv
// ----------------------------------------------------------------------------
// instruction_loader
//   Packs program bytes received from the debug unit's UART into 32-bit
//   big-endian instruction words and writes them, one per strobe, into the
//   fetch-stage instruction memory at consecutive word addresses starting at
//   zero. Loading stops on the HALT word (which is still written) or after
//   the last memory word has been written, and completion is reported on
//   o_done (with o_overflow set in the memory-full case).
//
//   Ports
//     i_clk    system clock, rising edge
//     i_reset  asynchronous, active-high reset
//     bus      instruction_loader_if.slave: start/byte inputs, memory write
//              outputs and status (see the interface header)
//
//   Parameters
//     NB          instruction / address width
//     NB_BYTE     UART byte width
//     TAM         instruction memory depth in words
//     HALT_INSTR  instruction word that terminates loading
// ----------------------------------------------------------------------------
module instruction_loader #(
  parameter int            NB         = 32,
  parameter int            NB_BYTE    = 8,
  parameter int            TAM        = 256,
  parameter logic [NB-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_loader_if.slave  bus
);

  // Address of the last memory word; writing it without HALT is an overflow.
  localparam logic [NB-1:0] LAST_ADDR = NB'(TAM - 1);
  localparam logic [NB-1:0] WORD_ONE  = NB'(1);
  localparam logic [NB-1:0] WORD_ZERO = NB'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r,    state_s;
  logic [1:0]    byte_cnt_r, byte_cnt_s;
  logic [NB-1:0] shift_r,    shift_s;
  logic [NB-1:0] instr_r,    instr_s;
  logic [NB-1:0] addr_r,     addr_s;
  logic          wr_r,       wr_s;
  logic          busy_r,     busy_s;
  logic          done_r,     done_s;
  logic          ovf_r,      ovf_s;
  logic [NB-1:0] count_r,    count_s;
  logic [NB-1:0] shifted_s;

  // Next-state and next-output logic for the IDLE/LOAD/DONE controller.
  always_comb begin
    state_s    = state_r;
    byte_cnt_s = byte_cnt_r;
    shift_s    = shift_r;
    instr_s    = instr_r;
    addr_s     = addr_r;
    wr_s       = 1'b0;
    ovf_s      = ovf_r;
    count_s    = count_r;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    // Older bytes move toward the MSB, so the first byte of a word lands in
    // the top byte once all four have arrived.
    shifted_s  = {shift_r[NB-NB_BYTE-1:0], bus.i_rx_data};

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          // Fresh load: forget any partial word and restart addressing at 0.
          // o_instruction keeps its last value until the first new word.
          state_s    = ST_LOAD;
          byte_cnt_s = 2'd0;
          shift_s    = WORD_ZERO;
          count_s    = WORD_ZERO;
          addr_s     = WORD_ZERO;
          ovf_s      = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      ST_LOAD: begin
        if (bus.i_rx_valid) begin
          shift_s    = shifted_s;
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            // Fourth byte: present the word together with its index. The
            // word index is the number of words already written.
            instr_s = shifted_s;
            addr_s  = count_r;
            wr_s    = 1'b1;
            count_s = count_r + WORD_ONE;
            if (shifted_s == HALT_INSTR) begin
              state_s = ST_DONE;
              ovf_s   = 1'b0;
            end else if (count_r == LAST_ADDR) begin
              // Memory full without HALT: stop before any address >= TAM.
              state_s = ST_DONE;
              ovf_s   = 1'b1;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            instr_s = instr_r;
          end
        end else begin
          byte_cnt_s = byte_cnt_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Status flags follow the state being entered so they are registered
    // in step with the state itself (o_done rises with the HALT strobe).
    if (state_s == ST_LOAD) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
    if (state_s == ST_DONE) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // State and output registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      byte_cnt_r <= 2'd0;
      shift_r    <= WORD_ZERO;
      instr_r    <= WORD_ZERO;
      addr_r     <= WORD_ZERO;
      wr_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      count_r    <= WORD_ZERO;
    end else begin
      state_r    <= state_s;
      byte_cnt_r <= byte_cnt_s;
      shift_r    <= shift_s;
      instr_r    <= instr_s;
      addr_r     <= addr_s;
      wr_r       <= wr_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      ovf_r      <= ovf_s;
      count_r    <= count_s;
    end
  end

  assign bus.o_instruction       = instr_r;
  assign bus.o_address           = addr_r;
  assign bus.o_instruction_write = wr_r;
  assign bus.o_busy              = busy_r;
  assign bus.o_done              = done_r;
  assign bus.o_overflow          = ovf_r;
  assign bus.o_word_count        = count_r;

endmodule : instruction_loader

// File: tb/tb_instruction_loader.sv
// ----------------------------------------------------------------------------
// tb_instruction_loader
//   Directed bench for instruction_loader with a 4-word memory, so the
//   memory-full case is reachable with a short byte stream. Inputs change
//   and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_instruction_loader;

  localparam int TAM = 4;

  logic i_clk;
  logic i_reset;

  int n_vec;
  int n_err;

  instruction_loader_if #(.NB(32), .NB_BYTE(8)) bus ();

  instruction_loader #(
    .NB         (32),
    .NB_BYTE    (8),
    .TAM        (TAM),
    .HALT_INSTR (32'hFFFF_FFFF)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Count one comparison and report it if it disagrees.
  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One isolated byte; returns on the falling edge after it was accepted.
  task automatic put(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_instr"}, bus.o_instruction, 32'h0);
    check_vec({tag, "_addr"},  bus.o_address, 32'h0);
    check_vec({tag, "_wr"},    {31'd0, bus.o_instruction_write}, 32'd0);
    check_vec({tag, "_busy"},  {31'd0, bus.o_busy}, 32'd0);
    check_vec({tag, "_done"},  {31'd0, bus.o_done}, 32'd0);
    check_vec({tag, "_ovf"},   {31'd0, bus.o_overflow}, 32'd0);
    check_vec({tag, "_cnt"},   bus.o_word_count, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [7:0]  b0;

    n_vec          = 0;
    n_err          = 0;
    i_reset        = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    tick();
    tick();
    check_all_zero("reset");
    i_reset = 1'b0;
    tick();

    // ---- Basic load terminated by HALT ----
    do_start();
    check_vec("basic_busy", {31'd0, bus.o_busy}, 32'd1);
    put(8'h20); put(8'h01); put(8'h00);
    check_vec("basic_nowr_partial", {31'd0, bus.o_instruction_write}, 32'd0);
    put(8'h05);
    check_vec("basic_wr1",    {31'd0, bus.o_instruction_write}, 32'd1);
    check_vec("basic_instr1", bus.o_instruction, 32'h2001_0005);
    check_vec("basic_addr1",  bus.o_address, 32'd0);
    check_vec("basic_cnt1",   bus.o_word_count, 32'd1);
    tick();
    check_vec("basic_wr1_low", {31'd0, bus.o_instruction_write}, 32'd0);
    put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF);
    check_vec("halt_wr",    {31'd0, bus.o_instruction_write}, 32'd1);
    check_vec("halt_instr", bus.o_instruction, 32'hFFFF_FFFF);
    check_vec("halt_addr",  bus.o_address, 32'd1);
    check_vec("halt_done",  {31'd0, bus.o_done}, 32'd1);
    check_vec("halt_busy",  {31'd0, bus.o_busy}, 32'd0);
    check_vec("halt_cnt",   bus.o_word_count, 32'd2);
    check_vec("halt_ovf",   {31'd0, bus.o_overflow}, 32'd0);
    tick();
    check_vec("halt_wr_low", {31'd0, bus.o_instruction_write}, 32'd0);
    check_vec("halt_done_hold", {31'd0, bus.o_done}, 32'd1);

    // ---- Reload from DONE ----
    do_start();
    check_vec("reload_done", {31'd0, bus.o_done}, 32'd0);
    check_vec("reload_busy", {31'd0, bus.o_busy}, 32'd1);
    check_vec("reload_cnt",  bus.o_word_count, 32'd0);
    check_vec("reload_ovf",  {31'd0, bus.o_overflow}, 32'd0);
    put(8'hA1); put(8'hB2); put(8'hC3); put(8'hD4);
    check_vec("reload_wr",    {31'd0, bus.o_instruction_write}, 32'd1);
    check_vec("reload_instr", bus.o_instruction, 32'hA1B2_C3D4);
    check_vec("reload_addr",  bus.o_address, 32'd0);

    // ---- Back-to-back bytes 11..18 ----
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'(8'h11 + i);
      tick();
      check_vec($sformatf("b2b_wr%0d", i), {31'd0, bus.o_instruction_write},
                ((i == 3) || (i == 7)) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check_vec("b2b_instr0", bus.o_instruction, 32'h1112_1314);
        check_vec("b2b_addr0",  bus.o_address, 32'd0);
      end
      if (i == 7) begin
        check_vec("b2b_instr1", bus.o_instruction, 32'h1516_1718);
        check_vec("b2b_addr1",  bus.o_address, 32'd1);
      end
    end
    bus.i_rx_valid = 1'b0;
    tick();
    check_vec("b2b_wr_end", {31'd0, bus.o_instruction_write}, 32'd0);
    check_vec("b2b_cnt",    bus.o_word_count, 32'd2);

    // ---- Overflow: 16 non-HALT bytes into a 4-word memory ----
    do_reset();
    do_start();
    for (int i = 0; i < 16; i++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'(i);
      tick();
      check_vec($sformatf("ovf_wr%0d", i), {31'd0, bus.o_instruction_write},
                ((i % 4) == 3) ? 32'd1 : 32'd0);
      if ((i % 4) == 3) begin
        b0    = 8'(i - 3);
        exp_w = {b0, 8'(b0 + 8'd1), 8'(b0 + 8'd2), 8'(b0 + 8'd3)};
        check_vec($sformatf("ovf_instr%0d", i / 4), bus.o_instruction, exp_w);
        check_vec($sformatf("ovf_addr%0d", i / 4), bus.o_address, 32'(i / 4));
      end
    end
    bus.i_rx_valid = 1'b0;
    check_vec("ovf_flag", {31'd0, bus.o_overflow}, 32'd1);
    check_vec("ovf_done", {31'd0, bus.o_done}, 32'd1);
    check_vec("ovf_busy", {31'd0, bus.o_busy}, 32'd0);
    check_vec("ovf_cnt",  bus.o_word_count, 32'd4);
    for (int i = 0; i < 4; i++) begin
      put(8'hAA);
      check_vec($sformatf("ovf_extra_wr%0d", i),
                {31'd0, bus.o_instruction_write}, 32'd0);
    end
    check_vec("ovf_extra_cnt",  bus.o_word_count, 32'd4);
    check_vec("ovf_extra_addr", bus.o_address, 32'd3);

    // ---- Ignored input: bytes in IDLE, start mid-LOAD ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(8'(8'h55 + i));
      check_vec($sformatf("idle_wr%0d", i), {31'd0, bus.o_instruction_write}, 32'd0);
    end
    check_vec("idle_busy", {31'd0, bus.o_busy}, 32'd0);
    do_start();
    put(8'h01); put(8'h02);
    do_start();
    check_vec("mid_start_busy", {31'd0, bus.o_busy}, 32'd1);
    check_vec("mid_start_wr",   {31'd0, bus.o_instruction_write}, 32'd0);
    put(8'h03);
    check_vec("mid_start_nowr", {31'd0, bus.o_instruction_write}, 32'd0);
    put(8'h04);
    check_vec("mid_start_wr1",   {31'd0, bus.o_instruction_write}, 32'd1);
    check_vec("mid_start_instr", bus.o_instruction, 32'h0102_0304);
    check_vec("mid_start_addr",  bus.o_address, 32'd0);
    check_vec("mid_start_cnt",   bus.o_word_count, 32'd1);

    // ---- Asynchronous reset after 6 bytes ----
    do_reset();
    do_start();
    put(8'h21); put(8'h22); put(8'h23); put(8'h24);
    put(8'h25); put(8'h26);
    #2 i_reset = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    i_reset = 1'b0;
    tick();
    do_start();
    put(8'h31); put(8'h32); put(8'h33); put(8'h34);
    check_vec("post_rst_wr",    {31'd0, bus.o_instruction_write}, 32'd1);
    check_vec("post_rst_instr", bus.o_instruction, 32'h3132_3334);
    check_vec("post_rst_addr",  bus.o_address, 32'd0);
    check_vec("post_rst_cnt",   bus.o_word_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instruction_loader

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Upstream neighbour of the fetch-stage instruction memory. It receives program bytes from the debug unit's UART receiver and packs every 4 bytes into one 32-bit instruction. Each packed word is presented with its word address and a one-cycle write strobe, which drive the instruction memory's instruction, address and write inputs. Loading ends on the HALT instruction or when the memory is full, and the loader then reports completion to the debug unit.

Parameters:
NB, 32, instruction/address width
NB_BYTE, 8, UART byte width
TAM, 256, instruction memory depth in words; word addresses run 0..TAM-1
HALT_INSTR, 32'hFFFFFFFF, instruction word that terminates loading

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  debug-unit command to begin a load; sampled as a level in IDLE/DONE
i_rx_valid  input  1  one-cycle strobe: i_rx_data holds a new byte
i_rx_data  input  NB_BYTE  received byte
o_instruction  output  NB  packed instruction word, to instruction memory
o_address  output  NB  word address of o_instruction (zero-extended index)
o_instruction_write  output  1  one-cycle write strobe, to instruction memory
o_busy  output  1  high while in LOAD
o_done  output  1  high while in DONE
o_overflow  output  1  load ended because TAM words were written without HALT
o_word_count  output  NB  number of words written in the current/last load

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0. Byte counter=0. Shift register=0.
- States: IDLE, LOAD, DONE. All outputs are registered.
- IDLE: i_start=1 -> LOAD. On entry, clear the byte counter, shift register, o_word_count, o_address and o_overflow. Bytes arriving in IDLE are ignored.
- DONE: o_done=1. i_start=1 -> LOAD, with the same clearing as IDLE. Otherwise stay in DONE. o_instruction, o_address and o_word_count hold their last values.
- LOAD: o_busy=1. On each i_rx_valid, shift[31:0] <= {shift[23:0], i_rx_data}. The first byte of a word ends up as bits 31:24 (big-endian). The byte counter increments modulo 4.
- Word completion: the 4th byte of a word is accepted at edge k. At edge k, the complete word is registered into o_instruction and o_address takes the current word index. During cycle k..k+1, o_instruction_write=1, and it is low on every other cycle. The word index and o_word_count increment at edge k. Latency from 4th i_rx_valid to strobe is 1 cycle.
- A byte arriving in the cycle where the strobe is high is accepted normally as byte 0 of the next word. Back-to-back i_rx_valid is allowed every cycle.
- HALT: if the completed word == HALT_INSTR, it is still written (strobe issued), and the state goes to DONE at the same edge k. o_done rises with the strobe. o_overflow=0.
- Overflow: if the completed word is not HALT and its address == TAM-1, it is written and the state goes to DONE with o_overflow=1. No address >= TAM is ever emitted.
- i_start while in LOAD is ignored. A partial word (fewer than 4 bytes) is never written.
- Reset mid-load: immediate return to IDLE with outputs cleared. The strobe drops asynchronously, and already-written memory contents are not affected.
- o_word_count = number of strobes issued since the last start. It lies in the range 0..TAM.

Test Plan:
- Basic load: start, bytes 20 01 00 05, then FF FF FF FF. Expect strobe 1 with o_instruction=32'h20010005 and o_address=0. Expect strobe 2 with 32'hFFFFFFFF and o_address=1. o_done=1 and o_busy=0 at the 2nd strobe, o_word_count=2, o_overflow=0.
- Latency/back-to-back: 8 consecutive-cycle i_rx_valid bytes 11..18. Strobe 1 cycle after byte 14 with 32'h11121314. Strobe 1 cycle after byte 18 with 32'h15161718 at address 1. Each strobe lasts exactly 1 cycle.
- Overflow: TAM=4, 16 bytes of non-HALT data. Expect 4 strobes at addresses 0..3, then DONE with o_overflow=1 and o_word_count=4. A further 4 bytes produce no strobe.
- Ignored input: bytes in IDLE, and i_start pulsed mid-LOAD after 2 bytes. No strobe and no restart occur; the word completes correctly after 2 more bytes.
- Reset mid-operation: assert i_reset asynchronously after 6 bytes. All outputs are 0 immediately and the state is IDLE. After restart, the first word is written at address 0.
- Reload from DONE: after a HALT-terminated load, i_start. o_done=0, o_busy=1, o_word_count=0, o_overflow=0, and the next word is written at address 0.
